icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/cpu_types_pkg.sv | 45 ++++
 rtl/caches_if.sv | 10 +
 rtl/datapath_cache_if.sv | 10 +
 rtl/icache_way_sel.sv | 39 +++
 rtl/icache_assoc.sv | 164 ++++++++++++++++
 tb/tb_icache_assoc.sv | 300 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// Shared instruction-cache types: FSM state, address split record and
// geometry helpers used to size the cache from its parameters.
package cpu_types_pkg;

    typedef enum logic {
        COMPARE = 1'b0,
        REFILL  = 1'b1
    } icache_state_t;

    // Right-justified address fields; callers cast each to its real width.
    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] idx;
        logic [31:0] woff;
        logic [1:0]  bsel;
    } icache_split_t;

    function automatic int unsigned woff_bits(input int unsigned blkwords);
        return $clog2(blkwords);
    endfunction

    function automatic int unsigned idx_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned blkwords);
        return 32 - 2 - idx_bits(sets) - woff_bits(blkwords);
    endfunction

    function automatic icache_split_t icache_split(input logic [31:0] addr,
                                                   input int unsigned sets,
                                                   input int unsigned blkwords);
        icache_split_t s;
        int unsigned   wb;
        int unsigned   ib;
        wb     = woff_bits(blkwords);
        ib     = idx_bits(sets);
        s.bsel = addr[1:0];
        s.woff = (addr >> 2) & (blkwords - 1);
        s.idx  = (addr >> (2 + wb)) & (sets - 1);
        s.tag  = addr >> (2 + wb + ib);
        return s;
    endfunction

endpackage

// File: rtl/caches_if.sv
// Cache <-> memory controller interface (instruction side only).
interface caches_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport icache (output iREN, iaddr, input iwait, iload);
    modport mem    (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/datapath_cache_if.sv
// Datapath <-> cache request interface (instruction side only).
interface datapath_cache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    modport icache (input imemREN, imemaddr, output ihit, imemload);
    modport dp     (output imemREN, imemaddr, input ihit, imemload);
endinterface

// File: rtl/icache_way_sel.sv
// Tag compare across the ways of one set and refill victim choice.
module icache_way_sel #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned TAG_W = 26
) (
    input  logic [WAYS-1:0]            i_valid,
    input  logic [WAYS-1:0][TAG_W-1:0] i_tags,
    input  logic                       i_lru,
    input  logic [TAG_W-1:0]           i_tag,
    output logic                       o_hit,
    output logic                       o_hit_way,
    output logic                       o_victim_way
);

    logic w_any_invalid;

    always_comb begin
        o_hit         = 1'b0;
        o_hit_way     = 1'b0;
        o_victim_way  = 1'b0;
        w_any_invalid = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (i_valid[w] && i_tags[w] == i_tag) begin
                o_hit     = 1'b1;
                o_hit_way = 1'(w);
            end
        end
        // Descending scan so the lowest-numbered invalid way wins.
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!i_valid[w-1]) begin
                w_any_invalid = 1'b1;
                o_victim_way  = 1'(w - 1);
            end
        end
        if (!w_any_invalid && WAYS == 2)
            o_victim_way = i_lru;
    end

endmodule

// File: rtl/icache_assoc.sv
// Blocking set-associative instruction cache (1 or 2 ways, LRU bit per set).
// Define ICACHE_STATS_EN to add the hit_count port and counter.
module icache_assoc
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS     = 8,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned BLKWORDS = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    datapath_cache_if.icache dcif,
    caches_if.icache         cif
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]      hit_count
`endif
);

    localparam int unsigned WOFF_W = woff_bits(BLKWORDS);
    localparam int unsigned IDX_W  = idx_bits(SETS);
    localparam int unsigned TAG_W  = tag_bits(SETS, BLKWORDS);
    localparam int unsigned CNT_W  = (WOFF_W == 0) ? 1 : WOFF_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLKWORDS - 1);

    icache_state_t r_state;
    icache_state_t w_next_state;

    logic [SETS-1:0]  r_valid [WAYS];
    logic [TAG_W-1:0] r_tag   [WAYS][SETS];
    logic [31:0]      r_data  [WAYS][SETS][BLKWORDS];
    logic [SETS-1:0]  r_lru;
    logic [CNT_W-1:0] r_cnt;
    logic [TAG_W-1:0] r_ltag;
    logic [IDX_W-1:0] r_lidx;
    logic             r_victim;

    icache_split_t             w_split;
    logic [TAG_W-1:0]          w_tag;
    logic [IDX_W-1:0]          w_idx;
    logic [CNT_W-1:0]          w_woff;
    logic [WAYS-1:0]           w_set_valid;
    logic [WAYS-1:0][TAG_W-1:0] w_set_tag;
    logic                      w_hit_any;
    logic                      w_hit_way;
    logic                      w_victim_way;
    logic                      w_ihit;
    logic                      w_miss;
    logic                      w_fill_done;
    logic [31:0]               w_refill_addr;
    logic                      w_unused_split;

    assign w_split = icache_split(dcif.imemaddr, SETS, BLKWORDS);
    assign w_tag   = TAG_W'(w_split.tag);
    assign w_idx   = IDX_W'(w_split.idx);
    assign w_woff  = CNT_W'(w_split.woff);
    assign w_unused_split = ^{w_split.bsel, w_split.tag[31:TAG_W],
                              w_split.idx[31:IDX_W], w_split.woff[31:CNT_W]};

    always_comb begin
        w_set_valid = '0;
        w_set_tag   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_set_valid[w] = r_valid[w][w_idx];
            w_set_tag[w]   = r_tag[w][w_idx];
        end
    end

    icache_way_sel #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W)
    ) u_way_sel (
        .i_valid      (w_set_valid),
        .i_tags       (w_set_tag),
        .i_lru        (r_lru[w_idx]),
        .i_tag        (w_tag),
        .o_hit        (w_hit_any),
        .o_hit_way    (w_hit_way),
        .o_victim_way (w_victim_way)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= COMPARE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_ihit       = 1'b0;
        w_miss       = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            COMPARE: begin
                if (dcif.imemREN) begin
                    if (w_hit_any) begin
                        w_ihit = 1'b1;
                    end else begin
                        w_miss       = 1'b1;
                        w_next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                if (!cif.iwait && r_cnt == LAST_WORD) begin
                    w_fill_done  = 1'b1;
                    w_next_state = COMPARE;
                end
            end
            default: w_next_state = COMPARE;
        endcase
    end

    assign w_refill_addr = (32'(r_ltag) << (IDX_W + WOFF_W + 2))
                         | (32'(r_lidx) << (WOFF_W + 2))
                         | (32'(r_cnt)  << 2);

    assign dcif.ihit     = w_ihit;
    assign dcif.imemload = w_ihit ? r_data[w_hit_way][w_idx][w_woff] : '0;
    assign cif.iREN      = (r_state == REFILL);
    assign cif.iaddr     = (r_state == REFILL) ? w_refill_addr : '0;

    // Victim is invalidated on the miss edge so a half-filled block never hits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid  <= '{default: '0};
            r_lru    <= '0;
            r_cnt    <= '0;
            r_ltag   <= '0;
            r_lidx   <= '0;
            r_victim <= 1'b0;
        end else begin
            if (w_ihit)
                r_lru[w_idx] <= ~w_hit_way;
            if (w_miss) begin
                r_ltag   <= w_tag;
                r_lidx   <= w_idx;
                r_cnt    <= '0;
                r_victim <= w_victim_way;
                r_valid[w_victim_way][w_idx] <= 1'b0;
            end
            if (r_state == REFILL && !cif.iwait)
                r_cnt <= w_fill_done ? '0 : r_cnt + 1'b1;
            if (w_fill_done) begin
                r_valid[r_victim][r_lidx] <= 1'b1;
                r_lru[r_lidx]             <= ~r_victim;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == REFILL && !cif.iwait)
            r_data[r_victim][r_lidx][r_cnt] <= cif.iload;
        if (w_fill_done)
            r_tag[r_victim][r_lidx] <= r_ltag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)       hit_count <= '0;
        else if (w_ihit) hit_count <= hit_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: LRU-list reference model, random and
// directed reads, memory responder with forced/random wait states.
module tb_icache_assoc;

    localparam int SETS     = 8;
    localparam int WAYS     = 2;
    localparam int BLKWORDS = 2;
    localparam int WOFF_W   = $clog2(BLKWORDS);

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    datapath_cache_if dcif();
    caches_if         cif();
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
`endif

    icache_assoc #(
        .SETS     (SETS),
        .WAYS     (WAYS),
        .BLKWORDS (BLKWORDS)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .dcif (dcif),
`ifdef ICACHE_STATS_EN
        .hit_count (hit_count),
`endif
        .cif  (cif)
    );

    int errors = 0;
    int checks = 0;
    int exp_hits = 0;

    logic [31:0] sb_q [$];
    int unsigned lines [SETS][$];

    int unsigned force_wait = 0;
    bit          rand_wait  = 0;
    logic [31:0] exp_base   = '0;
    int unsigned k          = 0;
    int unsigned stalls     = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return 32'hAAAA0000 + (a >> 2) - 32'd15;
    endfunction

    // Per-set recency list of resident block numbers, most recent first.
    function automatic bit model_access(input logic [31:0] addr);
        int unsigned blk;
        int unsigned s;
        blk = addr >> (2 + WOFF_W);
        s   = blk % SETS;
        for (int i = 0; i < lines[s].size(); i++) begin
            if (lines[s][i] == blk) begin
                lines[s].delete(i);
                lines[s].push_front(blk);
                return 1'b1;
            end
        end
        lines[s].push_front(blk);
        if (lines[s].size() > WAYS) void'(lines[s].pop_back());
        return 1'b0;
    endfunction

    // Memory responder: drives after each rising edge.
    initial begin
        cif.iwait = 1'b0;
        cif.iload = '0;
        forever begin
            @(posedge CLK);
            #1;
            cif.iload = memval(cif.iaddr);
            if (cif.iREN) begin
                if (force_wait > 0) begin
                    cif.iwait = 1'b1;
                    force_wait--;
                end else begin
                    cif.iwait = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
                end
            end else begin
                cif.iwait = 1'b0;
            end
        end
    end

    // Monitor: bus protocol checks and scoreboard pops on every ihit.
    initial begin
        forever begin
            @(negedge CLK);
            if (cif.iREN) begin
                check("ihit_in_refill", dcif.ihit, 1'b0);
                check("iaddr_refill", cif.iaddr, exp_base + 32'(4 * k));
                if (cif.iwait) stalls++;
                else           k++;
            end else begin
                check("iaddr_idle", cif.iaddr, 32'h0);
            end
            if (!dcif.imemREN) begin
                check("ihit_noreq", dcif.ihit, 1'b0);
                check("imemload_noreq", dcif.imemload, 32'h0);
            end
            if (dcif.ihit) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ihit: got ihit=1 expected no pending read at %0t", $time);
                end else begin
                    check("imemload", dcif.imemload, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
`endif
    endtask

    // Enters with time just after a rising edge; leaves the same way.
    task automatic do_reset();
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h40;
        nRST = 1'b0;
        #1;
        check("rst_ihit", dcif.ihit, 1'b0);
        check("rst_imemload", dcif.imemload, 32'h0);
        check("rst_iREN", cif.iREN, 1'b0);
        check("rst_iaddr", cif.iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'h0);
`endif
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        dcif.imemREN = 1'b0;
        for (int s = 0; s < SETS; s++) lines[s].delete();
        sb_q.delete();
        exp_hits   = 0;
        force_wait = 0;
        k          = 0;
    endtask

    task automatic idle(input int n);
        dcif.imemREN  = 1'b0;
        dcif.imemaddr = $urandom;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input bit abandon);
        bit          exp_hit;
        bit          got;
        bit          done;
        bit          saw_refill;
        int unsigned waited;
        int unsigned st0;
        exp_hit    = model_access(addr);
        if (exp_hit) abandon = 1'b0;
        exp_base   = addr & ~32'(BLKWORDS * 4 - 1);
        k          = 0;
        st0        = stalls;
        got        = 1'b0;
        done       = 1'b0;
        saw_refill = 1'b0;
        waited     = 0;
        if (!abandon) sb_q.push_back(memval(addr));
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = addr;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            if (dcif.ihit) begin
                got  = 1'b1;
                done = 1'b1;
            end else begin
                waited++;
                @(posedge CLK);
                #1;
                if (cif.iREN) begin
                    saw_refill    = 1'b1;
                    dcif.imemREN  = 1'($urandom_range(0, 1));
                    dcif.imemaddr = $urandom;
                end else if (saw_refill) begin
                    if (abandon) begin
                        dcif.imemREN = 1'b0;
                        done = 1'b1;
                    end else begin
                        dcif.imemREN  = 1'b1;
                        dcif.imemaddr = addr;
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL read_timeout: got no completion expected one for addr %h", addr);
        end
        check("hit_first_cycle", 32'(waited == 0), 32'(exp_hit));
        if (!exp_hit) begin
            check("refill_words", k, BLKWORDS);
            check("miss_latency", waited, 32'(1 + BLKWORDS + (stalls - st0)));
        end
        if (got) begin
            exp_hits++;
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        bit fired;
        dcif.imemREN  = 1'b0;
        dcif.imemaddr = '0;
        @(posedge CLK);
        #1;
        do_reset();

        do_read(32'h40, 1'b0);
        do_read(32'h44, 1'b0);
        do_read(32'h240, 1'b0);
        do_read(32'h40, 1'b0);
        do_read(32'h440, 1'b0);
        do_read(32'h40, 1'b0);
        do_read(32'h240, 1'b0);
        check_stats();

        force_wait = 3;
        do_read(32'h80, 1'b0);
        idle(3);

        // Reset while the second refill word is on the bus.
        do_reset();
        exp_base      = 32'h40;
        k             = 0;
        dcif.imemREN  = 1'b1;
        dcif.imemaddr = 32'h40;
        fired = 1'b0;
        for (int c = 0; c < 20 && !fired; c++) begin
            @(posedge CLK);
            #1;
            if (k == 1 && cif.iREN) fired = 1'b1;
        end
        check("midrefill_reached", 32'(fired), 32'h1);
        nRST = 1'b0;
        #1;
        check("midrefill_iREN", cif.iREN, 1'b0);
        do_reset();
        do_read(32'h40, 1'b0);

        do_reset();
        do_read(32'h40, 1'b1);
        do_read(32'h40, 1'b0);
        do_read(32'h44, 1'b0);
        do_read(32'h40, 1'b0);
        do_read(32'h80, 1'b1);
        do_read(32'h84, 1'b0);
        do_read(32'h44, 1'b0);
        check_stats();

        rand_wait = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(1, 3));
            end else begin
                int unsigned blk;
                int unsigned w;
                blk = $urandom_range(0, 23);
                w   = $urandom_range(0, BLKWORDS - 1);
                do_read(32'((blk * BLKWORDS + w) * 4), ($urandom_range(0, 9) == 0));
            end
        end
        check_stats();
        check("scoreboard_drain", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
